// File: rtl/idli_pkg.sv
// Shared types and default widths for the idli core.
// Control FSM states and slice counter type live here.
package idli_pkg;

  localparam int SLICE_W = 4;
  localparam int DATA_W  = 16;
  localparam int CTR_W   = $clog2(DATA_W / SLICE_W);

  typedef logic [CTR_W-1:0] ctr_t;

  typedef enum logic [2:0] {
    STARTUP,
    FETCH,
    RUN,
    REDIRECT,
    HALT
  } ctrl_state_t;

endpackage

// File: rtl/idli_ctrl_ctr_m.sv
// Free-running slice counter with first/last slice strobes.
// SLICES is a power of two, so the counter wraps naturally.
module idli_ctrl_ctr_m #(
  parameter  int SLICES = 4,
  localparam int CTR_W  = $clog2(SLICES)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CTR_W-1:0] ctr,
  output logic             first,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr <= '0;
    else        ctr <= ctr + 1'b1;
  end

  assign first = (ctr == '0);
  assign last  = &ctr;

endmodule

// File: rtl/idli_ctrl_m.sv
// Core sequencing: startup delay, fetch/run/redirect/halt FSM.
// All state changes happen on the last slice of a word.
module idli_ctrl_m #(
  parameter  int SLICE_W       = idli_pkg::SLICE_W,
  parameter  int DATA_W        = idli_pkg::DATA_W,
  parameter  int STARTUP_WORDS = 2,
  parameter  int TIMEOUT_WORDS = 15,
  localparam int SLICES        = DATA_W / SLICE_W,
  localparam int CTR_W         = $clog2(SLICES)
) (
  input  logic             i_ctrl_gck,
  input  logic             i_ctrl_rst_n,
  output logic [CTR_W-1:0] o_ctrl_ctr,
  output logic             o_ctrl_first,
  output logic             o_ctrl_last,
  input  logic             i_ctrl_instr_vld,
  output logic             o_ctrl_issue,
  input  logic             i_ctrl_redirect,
  output logic             o_ctrl_sqi_redirect,
  input  logic             i_ctrl_halt,
  output logic             o_ctrl_halted,
  output logic             o_ctrl_err
);

  import idli_pkg::*;

  localparam int CNT_W = $clog2(STARTUP_WORDS + TIMEOUT_WORDS + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  ctrl_state_t state;
  cnt_t        cnt;
  logic        redir_pend;
  logic        halt_pend;
  logic        redir_any;
  logic        halt_any;
  logic        live;

  idli_ctrl_ctr_m #(
    .SLICES (SLICES)
  ) u_ctr (
    .clk   (i_ctrl_gck),
    .rst_n (i_ctrl_rst_n),
    .ctr   (o_ctrl_ctr),
    .first (o_ctrl_first),
    .last  (o_ctrl_last)
  );

  // A pulse landing on the boundary cycle counts as already pending.
  assign redir_any = redir_pend | i_ctrl_redirect;
  assign halt_any  = halt_pend | i_ctrl_halt;
  assign live      = (state != STARTUP) && (state != HALT);

  assign o_ctrl_sqi_redirect =
    o_ctrl_last & live & redir_any & ~halt_any;

  always_ff @(posedge i_ctrl_gck or negedge i_ctrl_rst_n) begin
    if (!i_ctrl_rst_n) begin
      state         <= STARTUP;
      cnt           <= '0;
      o_ctrl_issue  <= 1'b0;
      o_ctrl_halted <= 1'b0;
      o_ctrl_err    <= 1'b0;
      redir_pend    <= 1'b0;
      halt_pend     <= 1'b0;
    end else if (state != HALT) begin
      redir_pend <= redir_any;
      halt_pend  <= halt_any;
      if (o_ctrl_last) begin
        priority case (1'b1)
          halt_any: begin
            state         <= HALT;
            o_ctrl_issue  <= 1'b0;
            o_ctrl_halted <= 1'b1;
            redir_pend    <= 1'b0;
            halt_pend     <= 1'b0;
          end
          (state == STARTUP): begin
            if (cnt == cnt_t'(STARTUP_WORDS - 1)) begin
              state <= FETCH;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          redir_any: begin
            state        <= REDIRECT;
            cnt          <= '0;
            o_ctrl_issue <= 1'b0;
            redir_pend   <= 1'b0;
          end
          (state == RUN): begin
            o_ctrl_issue <= i_ctrl_instr_vld;
          end
          i_ctrl_instr_vld: begin
            state        <= RUN;
            o_ctrl_issue <= 1'b1;
          end
          default: begin
            o_ctrl_issue <= 1'b0;
            if (cnt != cnt_t'(TIMEOUT_WORDS))
              cnt <= cnt + 1'b1;
            if (cnt >= cnt_t'(TIMEOUT_WORDS - 1))
              o_ctrl_err <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
